rocc_mac_accel: RTL and testbench

RoCC accelerator that consumes custom-instruction commands from the Ariane core inside the OpenPiton tile wrapper and returns register-writeback responses. It holds four 64-bit accumulators and supports write, read, add and a multi-cycle multiply-accumulate. Its command and response ports connect directly to the core's RoCC command and response ports.

---
 rtl/rocc_pkg.sv | 44 ++++
 rtl/rocc_seq_mul.sv | 72 +++++++
 rtl/rocc_mac_accel.sv | 158 +++++++++++++++
 tb/tb_rocc_mac_accel.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rocc_pkg.sv
// Shared RoCC command/response types and op encodings used by the core and
// by the accumulator accelerator.
package rocc_pkg;

    localparam logic [6:0]  ROCC_OPCODE_CUSTOM0 = 7'b0001011;
    localparam logic [63:0] ROCC_BAD_OP_DATA    = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [2:0] {
        ROCC_OP_WRITE = 3'd0,
        ROCC_OP_READ  = 3'd1,
        ROCC_OP_ADD   = 3'd2,
        ROCC_OP_MAC   = 3'd3,
        ROCC_OP_CLEAR = 3'd4
    } rocc_op_e;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic       xd;
        logic       xs1;
        logic       xs2;
        logic [4:0] rd;
        logic [6:0] opcode;
    } rocc_inst_t;

    typedef struct packed {
        rocc_inst_t  inst;
        logic [63:0] rs1;
        logic [63:0] rs2;
    } rocc_cmd_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [63:0] data;
    } rocc_resp_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_RESP
    } acc_state_e;

endpackage

// File: rtl/rocc_seq_mul.sv
// Iterative shift-add multiplier returning the low 64 bits of the product,
// consuming MulBitsPerCycle multiplier bits per cycle after a start pulse.
module rocc_seq_mul #(
    parameter int MulBitsPerCycle = 1
) (
    input  logic        clk_i,
    input  logic        reset_l,
    input  logic        start_i,
    input  logic [63:0] mcand_i,
    input  logic [63:0] mplier_i,
    output logic        done_o,
    output logic [63:0] product_o
);

    localparam logic [6:0] LastCnt = 7'(64 / MulBitsPerCycle - 1);

    logic [63:0] mcand_q, mcand_d;
    logic [63:0] mplier_q, mplier_d;
    logic [63:0] partial_q, partial_d;
    logic [6:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic [63:0] step;

    // Bits shifted out of the multiplicand only affect bits above 63, so the
    // truncated running sum is exactly the low half of the full product.
    assign step      = mcand_q * 64'(mplier_q[MulBitsPerCycle-1:0]);
    assign done_o    = busy_q && (cnt_q == LastCnt);
    assign product_o = partial_q + step;

    always_comb begin
        // NOTE: every _d gets its hold value first so no path infers a latch.
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        partial_d = partial_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        if (start_i) begin
            mcand_d   = mcand_i;
            mplier_d  = mplier_i;
            partial_d = '0;
            cnt_d     = '0;
            busy_d    = 1'b1;
        end else if (busy_q) begin
            partial_d = partial_q + step;
            mcand_d   = mcand_q << MulBitsPerCycle;
            mplier_d  = mplier_q >> MulBitsPerCycle;
            cnt_d     = cnt_q + 7'd1;
            if (cnt_q == LastCnt) begin
                busy_d = 1'b0;
            end
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop.
    always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) begin
            mcand_q   <= '0;
            mplier_q  <= '0;
            partial_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            partial_q <= partial_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
        end
    end

endmodule

// File: rtl/rocc_mac_accel.sv
// RoCC accumulator accelerator: write/read/add/clear in one cycle and an
// iterative multiply-accumulate, with a single held register-writeback response.
module rocc_mac_accel
    import rocc_pkg::*;
#(
    parameter int NrAcc           = 4,
    parameter int MulBitsPerCycle = 1
) (
    input  logic       clk_i,
    input  logic       reset_l,
    input  rocc_cmd_t  rocc_cmd_i,
    input  logic       rocc_cmd_valid_i,
    output logic       rocc_cmd_ready_o,
    output rocc_resp_t rocc_resp_o,
    output logic       rocc_resp_valid_o,
    input  logic       rocc_resp_ready_i,
    output logic       busy_o
);

    localparam int IdxW = (NrAcc > 1) ? $clog2(NrAcc) : 1;

    acc_state_e      state_q, state_d;
    logic [63:0]     acc_q [NrAcc];
    logic [63:0]     acc_d [NrAcc];
    logic [IdxW-1:0] idx_q, idx_d;
    logic [4:0]      rd_q, rd_d;
    logic            xd_q, xd_d;
    rocc_resp_t      resp_q, resp_d;
    logic            live_q, live_d;

    logic [IdxW-1:0] cmd_idx;
    logic            cmd_fire;
    logic            mul_start;
    logic            mul_done;
    logic [63:0]     mul_product;
    logic [63:0]     op_data;
    logic [63:0]     acc_sum;
    logic            unused_cmd_bits;

    // The accumulator index wraps modulo NrAcc (a power of two).
    assign cmd_idx  = IdxW'(rocc_cmd_i.inst.funct7[6:5] & 2'(NrAcc - 1));
    // live_q keeps ready low until the first edge after reset release.
    assign rocc_cmd_ready_o  = live_q && (state_q == ST_IDLE);
    assign cmd_fire          = rocc_cmd_valid_i && rocc_cmd_ready_o;
    assign rocc_resp_valid_o = (state_q == ST_RESP);
    assign rocc_resp_o       = resp_q;
    assign busy_o            = (state_q != ST_IDLE);

    assign unused_cmd_bits = ^{rocc_cmd_i.inst.funct7[4:3], rocc_cmd_i.inst.rs2,
                               rocc_cmd_i.inst.rs1, rocc_cmd_i.inst.xs1,
                               rocc_cmd_i.inst.xs2, rocc_cmd_i.inst.opcode};

    rocc_seq_mul #(
        .MulBitsPerCycle(MulBitsPerCycle)
    ) u_mul (
        .clk_i    (clk_i),
        .reset_l  (reset_l),
        .start_i  (mul_start),
        .mcand_i  (rocc_cmd_i.rs1),
        .mplier_i (rocc_cmd_i.rs2),
        .done_o   (mul_done),
        .product_o(mul_product)
    );

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        rd_d      = rd_q;
        xd_d      = xd_q;
        resp_d    = resp_q;
        live_d    = 1'b1;
        mul_start = 1'b0;
        op_data   = '0;
        acc_sum   = '0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    acc_sum = acc_q[cmd_idx] + rocc_cmd_i.rs1;
                    case (rocc_op_e'(rocc_cmd_i.inst.funct7[2:0]))
                        ROCC_OP_WRITE: begin
                            acc_d[cmd_idx] = rocc_cmd_i.rs1;
                            op_data        = rocc_cmd_i.rs1;
                        end
                        ROCC_OP_READ:  op_data = acc_q[cmd_idx];
                        ROCC_OP_ADD: begin
                            acc_d[cmd_idx] = acc_sum;
                            op_data        = acc_sum;
                        end
                        ROCC_OP_MAC:   mul_start = 1'b1;
                        ROCC_OP_CLEAR: begin
                            for (int i = 0; i < NrAcc; i++) begin
                                acc_d[i] = '0;
                            end
                            op_data = '0;
                        end
                        default:       op_data = ROCC_BAD_OP_DATA;
                    endcase
                    if (mul_start) begin
                        idx_d   = cmd_idx;
                        rd_d    = rocc_cmd_i.inst.rd;
                        xd_d    = rocc_cmd_i.inst.xd;
                        state_d = ST_MUL;
                    end else if (rocc_cmd_i.inst.xd) begin
                        resp_d.rd   = rocc_cmd_i.inst.rd;
                        resp_d.data = op_data;
                        state_d     = ST_RESP;
                    end
                end
            end
            ST_MUL: begin
                // The final partial step is folded into the accumulate edge.
                if (mul_done) begin
                    acc_sum      = acc_q[idx_q] + mul_product;
                    acc_d[idx_q] = acc_sum;
                    if (xd_q) begin
                        resp_d.rd   = rd_q;
                        resp_d.data = acc_sum;
                        state_d     = ST_RESP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RESP: begin
                if (rocc_resp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) begin
            state_q <= ST_IDLE;
            // NOTE: the accumulators are architectural state that must read
            // as zero after reset, so this flop array is reset explicitly.
            for (int i = 0; i < NrAcc; i++) begin
                acc_q[i] <= '0;
            end
            idx_q  <= '0;
            rd_q   <= '0;
            xd_q   <= 1'b0;
            resp_q <= '0;
            live_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            rd_q    <= rd_d;
            xd_q    <= xd_d;
            resp_q  <= resp_d;
            live_q  <= live_d;
        end
    end

endmodule

// File: tb/tb_rocc_mac_accel.sv
// Scoreboard bench for rocc_mac_accel: directed corner cases then randomized
// commands checked against an arithmetic model of the accumulator file.
module tb_rocc_mac_accel;
    import rocc_pkg::*;

    localparam int NR_ACC = 4;

    logic       clk_i = 1'b0;
    logic       reset_l = 1'b0;
    rocc_cmd_t  rocc_cmd_i = '0;
    logic       rocc_cmd_valid_i = 1'b0;
    logic       rocc_cmd_ready_o;
    rocc_resp_t rocc_resp_o;
    logic       rocc_resp_valid_o;
    logic       rocc_resp_ready_i = 1'b1;
    logic       busy_o;

    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_accept = 0;
    logic [63:0] model_acc [NR_ACC];
    rocc_resp_t  exp_q [$];
    bit          bp_rand = 1'b0;
    bit          ready_req = 1'b1;

    rocc_mac_accel #(.NrAcc(NR_ACC), .MulBitsPerCycle(1)) dut (
        .clk_i            (clk_i),
        .reset_l          (reset_l),
        .rocc_cmd_i       (rocc_cmd_i),
        .rocc_cmd_valid_i (rocc_cmd_valid_i),
        .rocc_cmd_ready_o (rocc_cmd_ready_o),
        .rocc_resp_o      (rocc_resp_o),
        .rocc_resp_valid_o(rocc_resp_valid_o),
        .rocc_resp_ready_i(rocc_resp_ready_i),
        .busy_o           (busy_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input logic [68:0] act, input logic [68:0] req);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: the accumulator file as plain array arithmetic.
    function automatic logic [63:0] model_apply(input logic [2:0] op, input int idx,
                                                input logic [63:0] a, input logic [63:0] b);
        case (op)
            3'd0: begin model_acc[idx] = a; return a; end
            3'd1: return model_acc[idx];
            3'd2: begin model_acc[idx] = model_acc[idx] + a; return model_acc[idx]; end
            3'd3: begin model_acc[idx] = model_acc[idx] + a * b; return model_acc[idx]; end
            3'd4: begin
                for (int i = 0; i < NR_ACC; i++) model_acc[i] = '0;
                return 64'd0;
            end
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    // Response-ready driver: sole writer of rocc_resp_ready_i, updated after each edge.
    initial forever begin
        @(posedge clk_i);
        #2;
        rocc_resp_ready_i = bp_rand ? ($urandom_range(3) != 0) : ready_req;
    end

    // Monitor: every completed response handshake is compared with the queue head.
    always @(negedge clk_i) begin
        if (reset_l && rocc_resp_valid_o && rocc_resp_ready_i) begin
            if (exp_q.size() == 0) begin
                check(1'b0, "unexpected_resp", rocc_resp_o, '0);
            end else begin
                rocc_resp_t e;
                e = exp_q.pop_front();
                check(rocc_resp_o == e, "resp", rocc_resp_o, e);
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [1:0] idx, input logic [1:0] fx,
                        input logic [4:0] rd, input logic xd,
                        input logic [63:0] a, input logic [63:0] b);
        int waitc;
        logic [63:0] d;
        rocc_resp_t r;
        waitc = 0;
        @(negedge clk_i);
        rocc_cmd_i             = '0;
        rocc_cmd_i.inst.funct7 = {idx, fx, op};
        rocc_cmd_i.inst.rd     = rd;
        rocc_cmd_i.inst.xd     = xd;
        rocc_cmd_i.inst.xs1    = 1'b1;
        rocc_cmd_i.inst.xs2    = 1'b1;
        rocc_cmd_i.inst.opcode = ROCC_OPCODE_CUSTOM0;
        rocc_cmd_i.rs1         = a;
        rocc_cmd_i.rs2         = b;
        rocc_cmd_valid_i       = 1'b1;
        while (!rocc_cmd_ready_o && waitc < 500) begin
            @(negedge clk_i);
            waitc++;
        end
        if (!rocc_cmd_ready_o) begin
            check(1'b0, "cmd_accept_timeout", 69'(waitc), 69'd500);
            rocc_cmd_valid_i = 1'b0;
            return;
        end
        @(posedge clk_i);
        d = model_apply(op, int'(idx) % NR_ACC, a, b);
        if (xd) begin
            r.rd   = rd;
            r.data = d;
            exp_q.push_back(r);
        end
        #1;
        rocc_cmd_valid_i = 1'b0;
        last_accept      = cyc;
    endtask

    initial begin
        int n;
        int prev;
        rocc_resp_t hold_exp;
        logic [63:0] v [8];
        for (int i = 0; i < NR_ACC; i++) model_acc[i] = '0;

        // Reset state while reset is held.
        #12;
        check(rocc_cmd_ready_o == 1'b0, "rst_cmd_ready", 69'(rocc_cmd_ready_o), 69'd0);
        check(rocc_resp_valid_o == 1'b0, "rst_resp_valid", 69'(rocc_resp_valid_o), 69'd0);
        check(busy_o == 1'b0, "rst_busy", 69'(busy_o), 69'd0);
        check(rocc_resp_o == '0, "rst_resp", rocc_resp_o, '0);
        @(negedge clk_i);
        reset_l = 1'b1;
        @(posedge clk_i);
        #1;
        check(rocc_cmd_ready_o == 1'b1, "ready_after_rst", 69'(rocc_cmd_ready_o), 69'd1);

        // WRITE then READ, rd echoed.
        send(3'd0, 2'd1, 2'd0, 5'd5, 1'b1, 64'h10, 64'h0);
        #1;
        check(rocc_resp_valid_o == 1'b1, "write_resp_next_cycle", 69'(rocc_resp_valid_o), 69'd1);
        check(rocc_cmd_ready_o == 1'b0, "ready_low_in_resp", 69'(rocc_cmd_ready_o), 69'd0);
        send(3'd1, 2'd1, 2'd0, 5'd7, 1'b1, 64'h0, 64'h0);

        // ADD wrap-around.
        send(3'd0, 2'd0, 2'd0, 5'd1, 1'b0, 64'd2, 64'h0);
        send(3'd2, 2'd0, 2'd0, 5'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);

        // MAC latency: accumulator result visible 64 edges after the accept edge.
        send(3'd0, 2'd2, 2'd0, 5'd3, 1'b0, 64'd5, 64'h0);
        send(3'd3, 2'd2, 2'd0, 5'd4, 1'b1, 64'd3, 64'd7);
        #1;
        check(busy_o == 1'b1 && rocc_cmd_ready_o == 1'b0, "mul_busy",
              69'({busy_o, rocc_cmd_ready_o}), 69'b10);
        n = 0;
        while (!rocc_resp_valid_o && n < 200) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        check(n == 64, "mac_latency", 69'(n), 69'd64);

        // MAC with a product that overflows 64 bits.
        send(3'd0, 2'd3, 2'd0, 5'd3, 1'b0, 64'h100, 64'h0);
        send(3'd3, 2'd3, 2'd0, 5'd6, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);

        // Unknown op and CLEAR.
        send(3'd6, 2'd1, 2'd0, 5'd8, 1'b1, 64'h1234, 64'h0);
        send(3'd4, 2'd2, 2'd0, 5'd9, 1'b1, 64'h0, 64'h0);
        send(3'd1, 2'd1, 2'd0, 5'd10, 1'b1, 64'h0, 64'h0);

        // Response backpressure.
        send(3'd0, 2'd2, 2'd0, 5'd0, 1'b0, 64'd26, 64'h0);
        ready_req = 1'b0;
        @(posedge clk_i);
        send(3'd1, 2'd2, 2'd0, 5'd11, 1'b1, 64'h0, 64'h0);
        hold_exp.rd   = 5'd11;
        hold_exp.data = 64'd26;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            check(rocc_resp_valid_o == 1'b1 && rocc_resp_o == hold_exp && rocc_cmd_ready_o == 1'b0,
                  "bp_hold", rocc_resp_o, hold_exp);
        end
        @(posedge clk_i);
        #1;
        ready_req = 1'b1;
        @(posedge clk_i);
        #1;
        ready_req = 1'b0;
        #2;
        check(rocc_cmd_ready_o == 1'b1 && rocc_resp_valid_o == 1'b0, "bp_release",
              69'({rocc_cmd_ready_o, rocc_resp_valid_o}), 69'b10);
        ready_req = 1'b1;

        // Back-to-back WRITEs without responses, one per cycle.
        prev = 0;
        for (int i = 0; i < 8; i++) begin
            v[i] = {$urandom, $urandom};
            send(3'd0, 2'(i % 4), 2'd0, 5'(i), 1'b0, v[i], 64'h0);
            if (i > 0) check(last_accept - prev == 1, "stream_rate", 69'(last_accept - prev), 69'd1);
            prev = last_accept;
        end
        for (int i = 0; i < 4; i++) send(3'd1, 2'(i), 2'd0, 5'(20 + i), 1'b1, 64'h0, 64'h0);

        // Reset in the middle of a MAC.
        send(3'd3, 2'd3, 2'd0, 5'd12, 1'b1, 64'd9, 64'd9);
        void'(exp_q.pop_back());
        repeat (10) @(posedge clk_i);
        #3;
        reset_l = 1'b0;
        #1;
        for (int i = 0; i < NR_ACC; i++) model_acc[i] = '0;
        check(rocc_resp_valid_o == 1'b0 && busy_o == 1'b0 && rocc_cmd_ready_o == 1'b0,
              "mid_mul_rst_ctrl", 69'({rocc_resp_valid_o, busy_o, rocc_cmd_ready_o}), 69'd0);
        check(rocc_resp_o == '0, "mid_mul_rst_resp", rocc_resp_o, '0);
        repeat (2) @(negedge clk_i);
        reset_l = 1'b1;
        @(posedge clk_i);
        #1;
        check(rocc_cmd_ready_o == 1'b1, "ready_after_rst2", 69'(rocc_cmd_ready_o), 69'd1);
        send(3'd1, 2'd3, 2'd0, 5'd13, 1'b1, 64'h0, 64'h0);
        send(3'd1, 2'd0, 2'd0, 5'd14, 1'b1, 64'h0, 64'h0);

        // Randomized commands with random response backpressure.
        bp_rand = 1'b1;
        for (int i = 0; i < 200; i++) begin
            logic [63:0] a;
            logic [63:0] b;
            a = ($urandom_range(3) == 0) ? 64'($urandom_range(15)) : {$urandom, $urandom};
            b = ($urandom_range(3) == 0) ? 64'($urandom_range(15)) : {$urandom, $urandom};
            send(3'($urandom_range(7)), 2'($urandom_range(3)), 2'($urandom_range(3)),
                 5'($urandom_range(31)), 1'($urandom_range(1)), a, b);
        end
        bp_rand = 1'b0;

        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk_i);
            n++;
        end
        repeat (3) @(posedge clk_i);
        check(exp_q.size() == 0, "drain", 69'(exp_q.size()), 69'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
